// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Front-end fetch stage of the dual-issue pipeline. It keeps the PC, issues
// 64-bit aligned requests on the instruction memory bus and splits each
// response into one or two instruction/address pairs. Those pairs go to the
// downstream instruction FIFO on two registered write lanes.
//
// Ports
//   clk             clock; all state updates on the rising edge
//   rst             synchronous active-low reset
//   redirect_en     branch/exception redirect this cycle (highest priority)
//   redirect_pc     redirect target; bits [1:0] are treated as zero
//   inst_req        memory request valid (combinational)
//   inst_addr       request address, {pc[31:3],3'b000} (combinational)
//   inst_addr_ok    memory accepted the request this cycle
//   inst_data_ok    memory response valid this cycle
//   inst_rdata      response; [31:0] word at addr, [63:32] word at addr+4
//   fifo_full       FIFO cannot take two more entries
//   write_en1/2     FIFO write strobes (registered, one-cycle pulses)
//   write_data1/2   instructions (zero when the matching strobe is zero)
//   write_address1/2 instruction PCs (zero when the matching strobe is zero)
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [63:0] inst_rdata,
  input  logic        fifo_full,
  output logic        write_en1,
  output logic        write_en2,
  output logic [31:0] write_data1,
  output logic [31:0] write_data2,
  output logic [31:0] write_address1,
  output logic [31:0] write_address2
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [63:0] hold_data_q, hold_data_d;
  logic [31:0] hold_pc_q, hold_pc_d;

  // A write is launched this cycle; lanes are filled from src_* below.
  logic        launch;
  logic [63:0] src_data;
  logic [31:0] src_pc;

  logic        wen_d   [2];
  logic        wen_q   [2];
  logic [31:0] wdata_d [2];
  logic [31:0] wdata_q [2];
  logic [31:0] waddr_d [2];
  logic [31:0] waddr_q [2];

  // A release from HOLD writes the buffered response; otherwise the live bus.
  assign src_data = (state_q == S_HOLD) ? hold_data_q : inst_rdata;
  assign src_pc   = (state_q == S_HOLD) ? hold_pc_q   : pc_q;

  assign inst_req  = (state_q == S_REQ) && !fifo_full && !redirect_en;
  assign inst_addr = {pc_q[31:3], 3'b000};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      hold_data_q <= '0;
      hold_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_data_q <= hold_data_d;
      hold_pc_q   <= hold_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_data_d = hold_data_q;
    hold_pc_d   = hold_pc_q;
    launch      = 1'b0;

    if (redirect_en) begin
      // Masking instead of slicing keeps every redirect_pc bit in use.
      pc_d        = redirect_pc & ~32'd3;
      hold_data_d = '0;
      hold_pc_d   = '0;
      unique case (state_q)
        // An addr_ok coinciding with the redirect still owes us one response.
        S_REQ:     state_d = inst_addr_ok ? S_DISCARD : S_REQ;
        S_WAIT:    state_d = inst_data_ok ? S_REQ : S_DISCARD;
        S_HOLD:    state_d = S_REQ;
        S_DISCARD: state_d = inst_data_ok ? S_REQ : S_DISCARD;
        default:   state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (inst_req && inst_addr_ok) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            if (!fifo_full) begin
              launch  = 1'b1;
              state_d = S_REQ;
            end else begin
              hold_data_d = inst_rdata;
              hold_pc_d   = pc_q;
              state_d     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!fifo_full) begin
            launch  = 1'b1;
            state_d = S_REQ;
          end
        end
        S_DISCARD: begin
          if (inst_data_ok) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end

    // An odd-word fetch yields one instruction, an even-word fetch yields two.
    if (launch) pc_d = src_pc + (src_pc[2] ? 32'd4 : 32'd8);
  end

  // Write lanes: lane 0 always carries the instruction at src_pc; lane 1
  // carries the upper word only when the fetch started on an even word.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign wen_d[gi]   = launch && ((gi == 0) || !src_pc[2]);
    assign wdata_d[gi] = !wen_d[gi]                 ? 32'd0 :
                         ((gi == 0) && !src_pc[2]) ? src_data[31:0] :
                                                     src_data[63:32];
    assign waddr_d[gi] = wen_d[gi] ? (src_pc + 32'(4 * gi)) : 32'd0;

    always_ff @(posedge clk) begin
      if (!rst) begin
        wen_q[gi]   <= 1'b0;
        wdata_q[gi] <= '0;
        waddr_q[gi] <= '0;
      end else begin
        wen_q[gi]   <= wen_d[gi];
        wdata_q[gi] <= wdata_d[gi];
        waddr_q[gi] <= waddr_d[gi];
      end
    end
  end

  assign write_en1      = wen_q[0];
  assign write_en2      = wen_q[1];
  assign write_data1    = wdata_q[0];
  assign write_data2    = wdata_q[1];
  assign write_address1 = waddr_q[0];
  assign write_address2 = waddr_q[1];

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed vector table for the documented scenarios, a short hand-written
// redirect-in-HOLD sequence, then randomized traffic against a
// transaction-level reference model (outstanding/drop/held flags plus PC).
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [63:0] inst_rdata;
  logic        fifo_full;
  logic        write_en1, write_en2;
  logic [31:0] write_data1, write_data2, write_address1, write_address2;

  int n_cmp = 0;
  int n_bad = 0;

  instruction_fetch #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .fifo_full      (fifo_full),
    .write_en1      (write_en1),
    .write_en2      (write_en2),
    .write_data1    (write_data1),
    .write_data2    (write_data2),
    .write_address1 (write_address1),
    .write_address2 (write_address2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          rst_n;
    bit          redir;
    logic [31:0] rpc;
    bit          aok;
    bit          dok;
    logic [63:0] rdata;
    bit          full;
    bit          req;
    logic [31:0] addr;
    bit          we1;
    bit          we2;
    logic [31:0] d1, a1, d2, a2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit chk, bit rst_n, bit redir, logic [31:0] rpc,
                              bit aok, bit dok, logic [63:0] rdata, bit full,
                              bit req, logic [31:0] addr, bit we1, bit we2,
                              logic [31:0] d1, logic [31:0] a1,
                              logic [31:0] d2, logic [31:0] a2);
    vec_t v;
    v.chk = chk; v.rst_n = rst_n; v.redir = redir; v.rpc = rpc;
    v.aok = aok; v.dok = dok; v.rdata = rdata; v.full = full;
    v.req = req; v.addr = addr; v.we1 = we1; v.we2 = we2;
    v.d1 = d1; v.a1 = a1; v.d2 = d2; v.a2 = a2;
    return v;
  endfunction

  task automatic drive(bit rst_n, bit redir, logic [31:0] rpc, bit aok, bit dok,
                       logic [63:0] rdata, bit full);
    rst          = rst_n;
    redirect_en  = redir;
    redirect_pc  = rpc;
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rdata;
    fifo_full    = full;
  endtask

  task automatic check(string name, bit req, logic [31:0] addr, bit we1, bit we2,
                       logic [31:0] d1, logic [31:0] a1,
                       logic [31:0] d2, logic [31:0] a2);
    logic [162:0] got, exp;
    got = {inst_req, inst_addr, write_en1, write_en2,
           write_data1, write_address1, write_data2, write_address2};
    exp = {req, addr, we1, we2, d1, a1, d2, a2};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got req/addr/we/d1/a1/d2/a2=%h required %h", name, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [31:0] m_pc;
  bit          m_owed;   // an accepted request still owes a response
  bit          m_drop;   // that response must be thrown away
  bit          m_held;   // a response is parked waiting for FIFO space
  logic [63:0] m_hbuf;
  bit          m_we1, m_we2;
  logic [31:0] m_d1, m_a1, m_d2, m_a2;
  int          n_writes = 0;

  task automatic model_reset();
    m_pc = RPC; m_owed = 0; m_drop = 0; m_held = 0; m_hbuf = '0;
    m_we1 = 0; m_we2 = 0; m_d1 = 0; m_a1 = 0; m_d2 = 0; m_a2 = 0;
  endtask

  // Emit the instructions of one 64-bit fetch block at the current PC.
  task automatic model_write(logic [63:0] d);
    if (m_pc % 8 == 0) begin
      m_we1 = 1; m_d1 = d[31:0];  m_a1 = m_pc;
      m_we2 = 1; m_d2 = d[63:32]; m_a2 = m_pc + 4;
      m_pc  = m_pc + 8;
    end else begin
      m_we1 = 1; m_d1 = d[63:32]; m_a1 = m_pc;
      m_pc  = m_pc + 4;
    end
    n_writes++;
    $display("write #%0d: %h@%h %s", n_writes, m_d1, m_a1,
             m_we2 ? $sformatf("+ %h@%h", m_d2, m_a2) : "(single)");
  endtask

  task automatic model_step(bit rst_n, bit redir, logic [31:0] rpc, bit aok,
                            bit dok, logic [63:0] rdata, bit full);
    bit idle;
    idle = !m_owed && !m_held;
    m_we1 = 0; m_we2 = 0; m_d1 = 0; m_a1 = 0; m_d2 = 0; m_a2 = 0;
    if (!rst_n) begin
      model_reset();
    end else if (redir) begin
      m_pc = {rpc[31:2], 2'b00};
      if (m_held) m_held = 0;
      else if (m_owed) begin
        if (dok) begin m_owed = 0; m_drop = 0; end
        else m_drop = 1;
      end else if (aok) begin
        m_owed = 1; m_drop = 1;
      end
    end else if (idle) begin
      if (!full && aok) begin m_owed = 1; m_drop = 0; end
    end else if (m_owed) begin
      if (dok) begin
        m_owed = 0;
        if (m_drop) m_drop = 0;
        else if (!full) model_write(rdata);
        else begin m_held = 1; m_hbuf = rdata; end
      end
    end else if (m_held && !full) begin
      m_held = 0;
      model_write(m_hbuf);
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);

    // chk rst red rpc aok dok rdata full | req addr we1 we2 d1 a1 d2 a2
    // reset / even PC
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,1,0,0,0, 1,RPC,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,1,64'h22222222_11111111,0, 0,RPC,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,RPC+8,1,1,32'h11111111,RPC,32'h22222222,RPC+4));
    // odd PC via redirect
    tbl.push_back(mk(1,1,1,32'h80000106,0,0,0,0, 0,RPC+8,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,1,0,0,0, 1,32'h80000100,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,1,64'hBBBBBBBB_AAAAAAAA,0, 0,32'h80000100,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,32'h80000108,1,0,32'hBBBBBBBB,32'h80000104,0,0));
    // full stall for 5 cycles
    tbl.push_back(mk(1,1,0,0,1,0,0,0, 1,32'h80000108,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,1,64'h44444444_33333333,1, 0,32'h80000108,0,0,0,0,0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,1,0,0,0,0,0,1, 0,32'h80000108,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 0,32'h80000108,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,32'h80000110,1,1,32'h33333333,32'h80000108,32'h44444444,32'h8000010C));
    // redirect in WAIT, data_ok three cycles later
    tbl.push_back(mk(1,1,0,0,1,0,0,0, 1,32'h80000110,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,1,32'h80001000,0,0,0,0, 0,32'h80000110,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 0,32'h80001000,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 0,32'h80001000,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,1,64'hDEADBEEF_DEADBEEF,0, 0,32'h80001000,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,32'h80001000,0,0,0,0,0,0));
    // redirect coincident with addr_ok=1
    tbl.push_back(mk(1,1,1,32'h80002000,1,0,0,0, 0,32'h80001000,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,1,64'h12345678_9ABCDEF0,0, 0,32'h80002000,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,32'h80002000,0,0,0,0,0,0));
    // redirect with addr_ok=0
    tbl.push_back(mk(1,1,1,32'h80003000,0,0,0,0, 0,32'h80002000,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,32'h80003000,0,0,0,0,0,0));
    // reset mid-WAIT, stale data_ok afterwards
    tbl.push_back(mk(1,1,0,0,1,0,0,0, 1,32'h80003000,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,32'h80003000,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,1,64'h55555555_55555555,0, 1,RPC,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,RPC,0,0,0,0,0,0));
    // wrap from 0xFFFFFFF8
    tbl.push_back(mk(1,1,1,32'hFFFFFFF8,0,0,0,0, 0,RPC,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,1,0,0,0, 1,32'hFFFFFFF8,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,1,64'h77777777_66666666,0, 0,32'hFFFFFFF8,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,32'h00000000,1,1,32'h66666666,32'hFFFFFFF8,32'h77777777,32'hFFFFFFFC));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst_n, tbl[i].redir, tbl[i].rpc, tbl[i].aok, tbl[i].dok,
            tbl[i].rdata, tbl[i].full);
      #1;
      if (tbl[i].chk) begin
        check($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].we1, tbl[i].we2,
              tbl[i].d1, tbl[i].a1, tbl[i].d2, tbl[i].a2);
        $display("vec %0d: req=%0b addr=%h we=%0b%0b", i, inst_req, inst_addr,
                 write_en1, write_en2);
      end
    end

    // Hand sequence: redirect while a response is parked in HOLD (pc=0 here).
    @(negedge clk); drive(1, 0, 0, 1, 0, 0, 0); #1;
    check("hold_req", 1, 32'h0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 1, 64'h99999999_88888888, 1); #1;
    check("hold_enter", 0, 32'h0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 1, 32'h00000103, 0, 0, 0, 0); #1;
    check("hold_redirect", 0, 32'h0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0); #1;
    check("hold_dropped", 1, 32'h100, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 1); #1;
    check("req_gated_full", 0, 32'h100, 0, 0, 0, 0, 0, 0);
    $display("hand sequence: redirect-in-HOLD done");

    // Randomized traffic against the reference model.
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit          r_rst, r_red, r_aok, r_dok, r_full;
      logic [31:0] r_rpc;
      logic [63:0] r_data;
      @(negedge clk);
      r_rst  = ($urandom_range(0, 299) != 0);
      r_red  = ($urandom_range(0, 15) == 0);
      r_rpc  = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
      r_full = ($urandom_range(0, 3) == 0);
      r_aok  = (!m_owed && !m_held) && ($urandom_range(0, 1) == 1);
      r_dok  = m_owed && ($urandom_range(0, 2) == 0);
      r_data = {$urandom, $urandom};
      drive(r_rst, r_red, r_rpc, r_aok, r_dok, r_data, r_full);
      #1;
      check($sformatf("rand%0d", cyc), !m_owed && !m_held && !r_full && !r_red,
            {m_pc[31:3], 3'b000}, m_we1, m_we2, m_d1, m_a1, m_d2, m_a2);
      model_step(r_rst, r_red, r_rpc, r_aok, r_dok, r_data, r_full);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end fetch stage of the dual-issue pipeline. Generates the PC, issues 64-bit aligned requests on the instruction memory bus, and packs each response into one or two instruction/address pairs. Writes those pairs into the downstream instruction FIFO through its write_en1/write_en2 port. Holds a response while the FIFO reports full, and discards in-flight fetches on a redirect.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, PC fetched first after reset

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-low reset
- redirect_en  input  1  branch/exception redirect this cycle
- redirect_pc  input  32  new PC; bits [1:0] ignored (treated as 0)
- inst_req  output  1  memory request valid
- inst_addr  output  32  request address, always {pc[31:3],3'b000}
- inst_addr_ok  input  1  request accepted this cycle (meaningful only when inst_req=1)
- inst_data_ok  input  1  response valid this cycle
- inst_rdata  input  64  response; [31:0] = word at addr, [63:32] = word at addr+4
- fifo_full  input  1  FIFO cannot accept two more entries
- write_en1, write_en2  output  1 each  FIFO write strobes
- write_data1, write_data2  output  32 each  instructions
- write_address1, write_address2  output  32 each  instruction PCs

## Operation
- Registers: pc[31:0], state, hold buffer (64-bit data plus the pc it belongs to), registered write outputs.
- States:
  - REQ: inst_req = !fifo_full && !redirect_en.
    - inst_req && inst_addr_ok → WAIT.
  - WAIT: awaiting inst_data_ok.
    - data_ok && !fifo_full → launch write, pc advances, → REQ.
    - data_ok && fifo_full → latch inst_rdata into hold buffer, → HOLD.
  - HOLD: when !fifo_full → launch write from hold buffer, pc advances, → REQ.
  - DISCARD: an accepted request was cancelled.
    - Wait for inst_data_ok, drop the data, → REQ.
    - No write is launched.
- Packing, based on the pc of the fetch:
  - pc[2]=0: write_en1=write_en2=1.
    - data1=rdata[31:0], addr1=pc.
    - data2=rdata[63:32], addr2=pc+4.
    - Next pc = pc+8.
  - pc[2]=1: write_en1=1, write_en2=0.
    - data1=rdata[63:32], addr1=pc.
    - Next pc = pc+4.
- write_en2 is never 1 while write_en1 is 0. When a write strobe is 0, its data and address outputs are 0.
- Only one outstanding memory request. Requests and responses are strictly in order.
- Redirect has priority over every other event in the same cycle:
  - pc ← {redirect_pc[31:2],2'b00}.
  - Registered write outputs are cleared next cycle; no write is launched in the redirect cycle.
  - REQ with inst_addr_ok=1 (request already accepted): → DISCARD.
  - REQ otherwise: stay in REQ. inst_req is forced 0 this cycle, so nothing is issued.
  - WAIT without data_ok: → DISCARD.
  - WAIT with data_ok: data dropped, → REQ.
  - HOLD: hold buffer dropped, → REQ.
  - DISCARD: stay in DISCARD, unless data_ok this cycle, then → REQ.
- Arithmetic: pc increments are modulo 2^32; 0xFFFFFFF8 + 8 wraps to 0.

## Timing
- Reset (rst=0 at a clock edge):
  - pc=RESET_PC, state=REQ.
  - All write outputs 0, hold buffer cleared.
  - Any in-flight response is ignored: inst_data_ok is disregarded until the first request after reset has been accepted.
- inst_req and inst_addr are combinational from state, pc, fifo_full and redirect_en. inst_req is high in the first cycle after reset release (if fifo_full=0).
- Write outputs are registered: a response accepted at edge N (data_ok, !fifo_full) drives write_en1/2 for exactly one cycle after edge N.
- Best-case throughput: one fetch per two cycles (REQ, WAIT with same-cycle data_ok is not permitted). The memory returns data_ok no earlier than the cycle after addr_ok.
- fifo_full is sampled in the same cycle as data_ok or as the HOLD release. At most one write is in flight, so a 2-entry write after sampling !fifo_full never overflows the 16-entry FIFO.
- Redirect takes effect on the next edge. The first request to the new target appears:
  - the cycle after redirect, from REQ/WAIT-with-data/HOLD;
  - the cycle after the discarded data_ok, from DISCARD.

## Test plan
- Reset/even PC: RESET_PC=0xBFC00000, release rst, addr_ok=1, next cycle data_ok with rdata=0x22222222_11111111.
  - → inst_addr=0xBFC00000 in the first cycle.
  - → next cycle write_en1/2=1, data1=0x11111111@0xBFC00000, data2=0x22222222@0xBFC00004.
  - → following inst_addr=0xBFC00008.
- Odd PC: redirect_pc=0x80000106, rdata=0xBBBBBBBB_AAAAAAAA.
  - → inst_addr=0x80000100.
  - → write_en1=1 only, data1=0xBBBBBBBB@0x80000104.
  - → next inst_addr=0x80000108.
- Full stall: fifo_full=1 when data_ok arrives, held 5 cycles.
  - → no writes and inst_req=0 during the stall.
  - → one cycle after fifo_full drops, the held pair is written with correct addresses.
- Redirect in WAIT: redirect to 0x80001000 before data_ok, data_ok 3 cycles later.
  - → no write for the stale data.
  - → next inst_addr=0x80001000.
- Redirect coincident with addr_ok, and with addr_ok=0 (two runs).
  - → addr_ok=1 case: DISCARD drops one response.
  - → addr_ok=0 case: inst_req=0 in the redirect cycle, then request to the new pc next cycle.
- Reset mid-WAIT plus wrap: assert rst while in WAIT and pulse data_ok afterwards; separately run from pc=0xFFFFFFF8.
  - → no write from the stale data_ok; fetch restarts at RESET_PC.
  - → after the pc=0xFFFFFFF8 fetch, next inst_addr=0x00000000.
